// File: rtl/dual_port_mem_arb_pkg.sv
// Shared types, defaults and the reference round-robin pick for dual_port_mem_arbiter.
// The optional statistics outputs of the top are enabled by MEM_ARB_STATS_EN.
package dual_port_mem_arb_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_ADDR     = 10;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_LOCK = 16;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 1'b0;
  localparam arb_state_t ST_LOCKED = 1'b1;

  // One-hot pick of the first valid bit at or above ptr, wrapping. Bits above
  // NREQ are expected to be zero, which makes the wrap equivalent to mod NREQ.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr);
    logic [7:0] grant;
    logic [2:0] idx;
    logic       found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/dual_port_mem_arbiter_rr_grant.sv
// Combinational round-robin grant: rotate valid so ptr sits at bit 0, isolate the
// lowest set bit, rotate back.
module rr_grant #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pri;
  logic [PW-1:0]   idx;

  always_comb begin
    rot     = '0;
    o_grant = '0;
    idx     = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx    = PW'((j + int'(i_ptr)) % NREQ);
      rot[j] = i_valid[idx];
    end
    pri = rot & (~rot + 1'b1);
    for (int j = 0; j < NREQ; j++) begin
      idx          = PW'((j + int'(i_ptr)) % NREQ);
      o_grant[idx] = pri[j];
    end
  end

endmodule

// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter with locked bursts sharing one memory-bank port among NREQ requesters.
// Define MEM_ARB_STATS_EN to add o_grant_cnt and o_force_release.
module dual_port_mem_arbiter
  import dual_port_mem_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR     = DEF_ADDR,
  parameter int NREQ     = DEF_NREQ,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ-1:0]       i_req_we,
  input  logic [NREQ-1:0]       i_req_lock,
  input  logic [NREQ*ADDR-1:0]  i_req_addr,
  input  logic [NREQ*WIDTH-1:0] i_req_din,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic                  o_en,
  output logic                  o_we,
  output logic [ADDR-1:0]       o_addr,
  output logic [WIDTH-1:0]      o_din,
  input  logic [WIDTH-1:0]      i_dout,
`ifdef MEM_ARB_STATS_EN
  output logic [NREQ*16-1:0]    o_grant_cnt,
  output logic                  o_force_release,
`endif
  output arb_state_t            o_dbg_state
);

  localparam int PW = $clog2(NREQ);

  // Handshake: a command moves when i_req_valid[k] && o_req_ready[k] on a rising edge;
  // ready is a function of valid and arbiter state only, and valid must never wait on ready.
  arb_state_t       state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d, ptr_q, ptr_d;
  logic [7:0]       lock_cnt_q, lock_cnt_d;
  logic             en_q, en_d, we_q, we_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [NREQ-1:0]  tag1_q, tag1_d, tag2_q, tag2_d;

  logic [NREQ-1:0]  rr_gnt, owner_oh, ready_c;
  logic [PW-1:0]    sel_idx, sel_nxt, owner_nxt;
  logic             sel_we, sel_lock, xfer;
  logic [ADDR-1:0]  sel_addr;
  logic [WIDTH-1:0] sel_din;

  rr_grant #(.NREQ(NREQ), .PW(PW)) u_rr_grant (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (rr_gnt)
  );

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    ready_c = (state_q == ST_LOCKED) ? (i_req_valid & owner_oh) : rr_gnt;
    if (i_rst) ready_c = '0;
  end

  always_comb begin
    sel_idx  = '0;
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ready_c[k]) begin
        sel_idx  = PW'(k);
        sel_we   = i_req_we[k];
        sel_lock = i_req_lock[k];
        sel_addr = i_req_addr[k*ADDR +: ADDR];
        sel_din  = i_req_din[k*WIDTH +: WIDTH];
      end
    end
    xfer      = |ready_c;
    sel_nxt   = (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + 1'b1;
    owner_nxt = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;
  end

  // In LOCKED a missing transfer means the owner dropped valid, which ends the burst.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          ptr_d = sel_nxt;
          if (sel_lock) begin
            state_d    = ST_LOCKED;
            owner_d    = sel_idx;
            lock_cnt_d = 8'd1;
          end
        end
      end
      default: begin
        if (!xfer || !sel_lock || (lock_cnt_q + 8'd1 == 8'(MAX_LOCK))) begin
          state_d    = ST_IDLE;
          ptr_d      = owner_nxt;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    en_d   = xfer;
    we_d   = xfer & sel_we;
    addr_d = xfer ? sel_addr : addr_q;
    din_d  = xfer ? sel_din : din_q;
    tag1_d = (xfer && !sel_we) ? ready_c : '0;
    tag2_d = tag1_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
    end
  end

  assign o_req_ready = ready_c;
  assign o_rsp_valid = tag2_q;
  assign o_rsp_data  = i_dout;
  assign o_en        = en_q;
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_din       = din_q;
  assign o_dbg_state = state_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] gcnt_q [NREQ];
  logic [15:0] gcnt_d [NREQ];
  logic        force_q, force_d;

  always_comb begin
    force_d = (state_q == ST_LOCKED) && xfer && sel_lock &&
              (lock_cnt_q + 8'd1 == 8'(MAX_LOCK));
    for (int k = 0; k < NREQ; k++) begin
      gcnt_d[k] = gcnt_q[k];
      if (ready_c[k] && (gcnt_q[k] != 16'hFFFF)) gcnt_d[k] = gcnt_q[k] + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      force_q <= 1'b0;
      for (int k = 0; k < NREQ; k++) gcnt_q[k] <= '0;
    end else begin
      force_q <= force_d;
      for (int k = 0; k < NREQ; k++) gcnt_q[k] <= gcnt_d[k];
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int k = 0; k < NREQ; k++) o_grant_cnt[k*16 +: 16] = gcnt_q[k];
  end

  assign o_force_release = force_q;
`endif

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Bench for dual_port_mem_arbiter: behavioural memory, arbitration model, read scoreboard.
// Stats checks compile in when MEM_ARB_STATS_EN is defined.
module tb_dual_port_mem_arbiter;
  import dual_port_mem_arb_pkg::*;

  localparam int W  = 8;
  localparam int A  = 10;
  localparam int N  = 4;
  localparam int ML = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid, we, lock;
  logic [N*A-1:0] addr;
  logic [N*W-1:0] din;
  logic [N-1:0]   ready, rsp_valid;
  logic [W-1:0]   rsp_data, o_din, mem_dout;
  logic           o_en, o_we;
  logic [A-1:0]   o_addr;
  arb_state_t     dbg_state;
`ifdef MEM_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic            force_release;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dual_port_mem_arbiter #(.WIDTH(W), .ADDR(A), .NREQ(N), .MAX_LOCK(ML)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (valid),
    .i_req_we        (we),
    .i_req_lock      (lock),
    .i_req_addr      (addr),
    .i_req_din       (din),
    .o_req_ready     (ready),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_data      (rsp_data),
    .o_en            (o_en),
    .o_we            (o_we),
    .o_addr          (o_addr),
    .o_din           (o_din),
    .i_dout          (mem_dout),
`ifdef MEM_ARB_STATS_EN
    .o_grant_cnt     (grant_cnt),
    .o_force_release (force_release),
`endif
    .o_dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] init_val(input int i);
    return 8'((i * 7) + 3);
  endfunction

  // ---------------- memory bank port model ----------------
  logic [W-1:0] mem [0:(1<<A)-1];
  logic         mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << A); i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (o_en) begin
      if (o_we) mem[o_addr] <= o_din;
      else      mem_dout    <= mem[o_addr];
    end
  end

  // ---------------- scoreboard and reference model ----------------
  // exp_q entry: [31:16] due cycle, [15:8] one-hot tag, [7:0] data
  logic [31:0]  exp_q[$];
  logic [W-1:0] shadow [0:(1<<A)-1];
  bit           shadow_init = 1'b0;
  int           ptr_m, owner_m, cnt_m;
  bit           locked_m;
  logic [N-1:0] prev_xf, last_xfer;
  logic         prev_we;
  logic [A-1:0] prev_addr;
  logic [W-1:0] prev_din;
  int           wait_cnt [N];
  int           grant_exp [N];
  int           force_exp, force_seen;

  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_rdy, xf;
    logic [31:0]  e;
    logic [A-1:0] a;
    int           j;
    if (!shadow_init) begin
      for (int i = 0; i < (1 << A); i++) shadow[i] = init_val(i);
      shadow_init = 1'b1;
    end
    if (rst) begin
      exp_q.delete();
      ptr_m = 0; owner_m = 0; cnt_m = 0; locked_m = 1'b0;
      prev_xf = '0; prev_we = 1'b0; prev_addr = '0; prev_din = '0; last_xfer = '0;
      force_exp = 0; force_seen = 0;
      for (int k = 0; k < N; k++) begin
        wait_cnt[k]  = 0;
        grant_exp[k] = 0;
      end
    end else begin
      exp_rdy = '0;
      if (locked_m) begin
        if (valid[owner_m]) exp_rdy[owner_m] = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          j = (ptr_m + i) % N;
          if (valid[j] && exp_rdy == '0) exp_rdy[j] = 1'b1;
        end
      end
      chk("ready", 32'(ready), 32'(exp_rdy));
      chk("pipe_en", 32'(o_en), 32'(|prev_xf));
      chk("pipe_we", 32'(o_we), 32'(prev_we));
      if (|prev_xf) chk("pipe_addr", 32'(o_addr), 32'(prev_addr));
      if (prev_we)  chk("pipe_din", 32'(o_din), 32'(prev_din));
      if (exp_q.size() > 0 && exp_q[0][31:16] == cyc[15:0]) begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e[15:8]));
        chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 0);
      end
`ifdef MEM_ARB_STATS_EN
      if (force_release) force_seen++;
`endif
      xf        = ready & valid;
      last_xfer = xf;
      prev_xf   = xf;
      prev_we   = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (xf[k]) begin
          grant_exp[k]++;
          a         = addr[k*A +: A];
          prev_addr = a;
          prev_din  = din[k*W +: W];
          prev_we   = we[k];
          if (we[k]) begin
            shadow[a] = din[k*W +: W];
          end else begin
            e          = '0;
            e[31:16]   = cyc[15:0] + 16'd2;
            e[8 + k]   = 1'b1;
            e[7:0]     = shadow[a];
            exp_q.push_back(e);
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!valid[k]) wait_cnt[k] = 0;
        else if (xf[k]) begin
          chk("starve", 32'(wait_cnt[k] <= N - 1), 1);
          wait_cnt[k] = 0;
        end else if (xf != '0 && !locked_m) wait_cnt[k]++;
      end
      if (locked_m) begin
        if (exp_rdy == '0) begin
          locked_m = 1'b0;
          ptr_m    = (owner_m + 1) % N;
        end else begin
          cnt_m++;
          if (!lock[owner_m] || cnt_m == ML) begin
            if (lock[owner_m]) force_exp++;
            locked_m = 1'b0;
            ptr_m    = (owner_m + 1) % N;
          end
        end
      end else if (exp_rdy != '0) begin
        j = 0;
        for (int k = 0; k < N; k++) if (exp_rdy[k]) j = k;
        ptr_m = (j + 1) % N;
        if (lock[j]) begin
          locked_m = 1'b1;
          owner_m  = j;
          cnt_m    = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic v, input logic w, input logic l,
                         input logic [A-1:0] ad, input logic [W-1:0] d);
    valid[k]       = v;
    we[k]          = w;
    lock[k]        = l;
    addr[k*A +: A] = ad;
    din[k*W +: W]  = d;
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1; valid = '0; we = '0; lock = '0; addr = '0; din = '0;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 1'b0, 10'(k + 16), 8'h00);
    step(); step();
    mid();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_en", 32'(o_en), 0);
    chk("rst_we", 32'(o_we), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_din", 32'(o_din), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_state", 32'(dbg_state), 0);
    step();
    rst = 1'b0;

    // round-robin order after reset with everyone valid
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("rr_grant", 32'(ready), 32'(rr_seq[i]));
      chk("rr_en", 32'(o_en), 32'(i > 0));
      step();
    end
    valid = '0;
    mid(); step();

    // req2 write then read-back of addr 0x003
    set_req(2, 1'b1, 1'b1, 1'b0, 10'h003, 8'h5A);
    mid(); chk("wr_grant", 32'(ready), 4); step();
    set_req(2, 1'b1, 1'b0, 1'b0, 10'h003, 8'h00);
    mid();
    chk("rd_grant", 32'(ready), 4);
    chk("wr_en", 32'(o_en), 1);
    chk("wr_we", 32'(o_we), 1);
    chk("wr_addr", 32'(o_addr), 3);
    chk("wr_din", 32'(o_din), 32'h5A);
    step();
    set_req(2, 1'b0, 1'b0, 1'b0, 10'h003, 8'h00);
    mid();
    chk("rd_rsp_c1", 32'(rsp_valid), 0);
    chk("rd_we", 32'(o_we), 0);
    chk("rd_addr", 32'(o_addr), 3);
    step();
    mid();
    chk("rd_rsp_c2", 32'(rsp_valid), 4);
    chk("rd_data", 32'(rsp_data), 32'h5A);
    step();

    // req1 locked burst of 5 beats with req0/req3 competing
    set_req(0, 1'b1, 1'b0, 1'b0, 10'd7, 8'h00);
    mid(); chk("pre_lock", 32'(ready), 1); step();
    set_req(3, 1'b1, 1'b0, 1'b0, 10'd9, 8'h00);
    for (int b = 0; b < 5; b++) begin
      set_req(1, 1'b1, 1'b0, 1'(b < 4), 10'd8, 8'h00);
      mid();
      chk("lock_grant", 32'(ready), 2);
      chk("lock_state", 32'(dbg_state), 32'(b > 0));
      step();
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 10'd8, 8'h00);
    mid();
    chk("post_lock", 32'(ready), 8);
    chk("unlock_state", 32'(dbg_state), 0);
    step();
    mid(); chk("post_lock2", 32'(ready), 1); step();
    valid = '0; lock = '0;

    // forced release after MAX_LOCK beats
    set_req(3, 1'b1, 1'b0, 1'b0, 10'd9, 8'h00);
    mid(); chk("pre_force", 32'(ready), 8); step();
    set_req(3, 1'b0, 1'b0, 1'b0, 10'd9, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b1, 10'd12, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 10'd13, 8'h00);
    for (int b = 0; b < ML; b++) begin
      mid(); chk("force_grant", 32'(ready), 1); step();
    end
    mid(); chk("force_next", 32'(ready), 2); step();
    mid(); chk("relock", 32'(ready), 1); step();
    valid = '0; lock = '0;
    mid(); chk("idle_none", 32'(ready), 0); step();
`ifdef MEM_ARB_STATS_EN
    chk("force_pulse", 32'(force_seen), 1);
    for (int k = 0; k < N; k++) chk("grant_cnt", 32'(grant_cnt[k*16 +: 16]), 32'(grant_exp[k]));
`endif

    // reset in the cycle after a read transfer
    set_req(2, 1'b1, 1'b0, 1'b0, 10'd5, 8'h00);
    mid(); chk("rst_rd_grant", 32'(ready), 4); step();
    valid = '0;
    rst   = 1'b1;
    mid(); chk("rst_mid_rsp", 32'(rsp_valid), 0); step();
    rst = 1'b0;
    mid();
    chk("post_rst_rsp", 32'(rsp_valid), 0);
    chk("post_rst_en", 32'(o_en), 0);
    chk("post_rst_we", 32'(o_we), 0);
    chk("post_rst_addr", 32'(o_addr), 0);
    chk("post_rst_din", 32'(o_din), 0);
    chk("post_rst_ready", 32'(ready), 0);
    chk("post_rst_state", 32'(dbg_state), 0);
    step();
    mid(); chk("post_rst_rsp2", 32'(rsp_valid), 0); step();

    // random traffic; commands held until they transfer
    repeat (2000) begin
      for (int k = 0; k < N; k++) begin
        if (!valid[k] || last_xfer[k])
          set_req(k, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0), 10'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)));
      end
      step();
    end
    valid = '0; lock = '0;
    repeat (4) step();
    chk("drain", 32'(exp_q.size()), 0);
`ifdef MEM_ARB_STATS_EN
    chk("force_total", 32'(force_seen), 32'(force_exp));
    for (int k = 0; k < N; k++) chk("grant_cnt_rand", 32'(grant_cnt[k*16 +: 16]), 32'(grant_exp[k]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
